// File: rtl/rst_req_ctrl_if.sv
// Reset-request handshake bundle between the CRG register slice (initiator)
// and whoever drives it. The slave modport is the controller's view.
interface rst_req_ctrl_if;
  logic       sw_req_i;
  logic       arst_n_i;
  logic       arst_req_o;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;
  logic [7:0] req_cnt_o;

  modport slave (
    input  sw_req_i,
    input  arst_n_i,
    output arst_req_o,
    output busy_o,
    output done_o,
    output timeout_o,
    output req_cnt_o
  );

  modport master (
    output sw_req_i,
    output arst_n_i,
    input  arst_req_o,
    input  busy_o,
    input  done_o,
    input  timeout_o,
    input  req_cnt_o
  );
endinterface

// File: rtl/rst_req_ctrl.sv
// Reset-request initiator: turns a one-cycle sw_req_i into a full assert/confirm/release/confirm
// handshake with the output-reset generator. Optional completed-request counter: RST_REQ_CNT_EN.
module rst_req_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic          ref_clk_i,
  input  logic          glob_rst_ni,
  rst_req_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   arst_n_s;
  logic                   arst_req_q, arst_req_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;

  // arst_n_i is asynchronous to ref_clk_i; the chain resets low so the
  // returned reset reads as asserted until it has been sampled cleanly.
  always_ff @(posedge ref_clk_i) begin
    if (!glob_rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.arst_n_i};
    end
  end

  assign arst_n_s = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge ref_clk_i) begin
    if (!glob_rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      arst_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arst_req_q <= arst_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.sw_req_i) state_d = ST_ASSERT;
      end
      // The exit test comes first so an exit on the last allowed cycle beats the timeout.
      ST_ASSERT: begin
        if ((cnt_q >= HOLD_LAST) && !arst_n_s) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (arst_n_s) begin
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase counter: zero on every state entry, counts only in the two wait phases, sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == ST_ASSERT) || (state_q == ST_RELEASE)) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with the state they describe.
  always_comb begin
    arst_req_d = (state_d == ST_ASSERT);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  assign bus.arst_req_o = arst_req_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.timeout_o  = timeout_q;

`ifdef RST_REQ_CNT_EN
  logic [7:0] req_cnt_q;

  always_ff @(posedge ref_clk_i) begin
    if (!glob_rst_ni) begin
      req_cnt_q <= 8'h00;
    end else if (done_q && (req_cnt_q != 8'hFF)) begin
      req_cnt_q <= req_cnt_q + 8'd1;
    end
  end

  assign bus.req_cnt_o = req_cnt_q;
`else
  assign bus.req_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Self-checking bench for rst_req_ctrl: a delayed-inverter model of the output-reset generator,
// with expected waveforms derived in closed form from the handshake timing rules.
module tb_rst_req_ctrl;

  localparam int H = 16;
  localparam int T = 1024;
  localparam int S = 2;

  localparam int K_NORMAL   = 0;
  localparam int K_STUCK_HI = 1;
  localparam int K_STUCK_LO = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rst_req_ctrl_if bus_if ();

  rst_req_ctrl #(
    .HOLD_CYCLES   (H),
    .TIMEOUT_CYCLES(T),
    .SYNC_STAGES   (S)
  ) dut (
    .ref_clk_i  (clk),
    .glob_rst_ni(rst_n),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   env_delay = 0;
  int   env_mode  = K_NORMAL;
  int   exp_cnt   = 0;
  logic hist[$];
  logic env_low   = 1'b0;

  // Generator model: arst_n_i follows !arst_req_o delayed env_delay cycles,
  // optionally stuck high, or latched low once it first falls.
  initial begin
    logic v;
    bus_if.arst_n_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      hist.push_front(bus_if.arst_req_o);
      if (hist.size() > 2100) void'(hist.pop_back());
      v = (env_delay < hist.size()) ? !hist[env_delay] : 1'b1;
      if (env_mode == K_STUCK_HI) begin
        v = 1'b1;
      end else if (env_mode == K_STUCK_LO) begin
        if (env_low) v = 1'b0;
        else if (!v) env_low = 1'b1;
      end else begin
        env_low = 1'b0;
      end
      bus_if.arst_n_i = v;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus_if.sw_req_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus_if.arst_req_o, bus_if.busy_o, bus_if.done_o, bus_if.timeout_o} !== 4'b0000) begin
        n_fail++;
        $display("FAIL %s idle outputs req/busy/done/to got %b%b%b%b required 0000", tag,
                 bus_if.arst_req_o, bus_if.busy_o, bus_if.done_o, bus_if.timeout_o);
      end
      n_checks++;
      if (bus_if.req_cnt_o !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL %s idle req_cnt_o got %0d required %0d", tag, bus_if.req_cnt_o, exp_cnt);
      end
    end
  endtask

  // One request with sw_req_i high for 'hold' cycles from r=-1; extra_mode adds a
  // stray pulse (1: random busy cycle, 2: DONE cycle). r=0 is the first ASSERT cycle.
  task automatic run_sequence(input int kind, input int hold, input int extra_mode, input string tag);
    int k, j, req_end, busy_end, done_r, to_r, last, extra_r;
    bit assert_to;
    logic e_req, e_busy, e_done, e_to;
    assert_to = (kind == K_STUCK_HI) || (env_delay + S > T - 1);
    k = (H - 1 > env_delay + S) ? H - 1 : env_delay + S;
    j = env_delay + S;
    done_r = -100;
    to_r   = -100;
    if (assert_to) begin
      req_end = T - 1; busy_end = T - 1; to_r = T;
    end else if (kind == K_STUCK_LO) begin
      req_end = k; busy_end = k + T; to_r = k + 1 + T;
    end else begin
      req_end = k; busy_end = k + j + 2; done_r = busy_end;
    end
    last = busy_end + 4;
    extra_r = -100;
    if (extra_mode == 1) extra_r = int'($urandom_range(0, busy_end));
    else if (extra_mode == 2) extra_r = busy_end;

    for (int r = -1; r <= last; r++) begin
      @(posedge clk);
      #1;
      bus_if.sw_req_i = (r < hold - 1) || (r == extra_r);
      @(negedge clk);
      e_req  = (r >= 0) && (r <= req_end);
      e_busy = (r >= 0) && (r <= busy_end);
      e_done = (r == done_r);
      e_to   = (r == to_r);
      n_checks++;
      if (bus_if.arst_req_o !== e_req) begin
        n_fail++;
        $display("FAIL %s arst_req_o r=%0d got %b required %b", tag, r, bus_if.arst_req_o, e_req);
      end
      n_checks++;
      if (bus_if.busy_o !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy_o r=%0d got %b required %b", tag, r, bus_if.busy_o, e_busy);
      end
      n_checks++;
      if (bus_if.done_o !== e_done) begin
        n_fail++;
        $display("FAIL %s done_o r=%0d got %b required %b", tag, r, bus_if.done_o, e_done);
      end
      n_checks++;
      if (bus_if.timeout_o !== e_to) begin
        n_fail++;
        $display("FAIL %s timeout_o r=%0d got %b required %b", tag, r, bus_if.timeout_o, e_to);
      end
    end
    bus_if.sw_req_i = 1'b0;
`ifdef RST_REQ_CNT_EN
    if (done_r >= 0) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
`endif
    n_checks++;
    if (bus_if.req_cnt_o !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s req_cnt_o after sequence got %0d required %0d", tag, bus_if.req_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus_if.sw_req_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus_if.arst_req_o, bus_if.busy_o, bus_if.done_o, bus_if.timeout_o, bus_if.req_cnt_o} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset outputs req/busy/done/to/cnt got %b%b%b%b/%0d required 0000/0", bus_if.arst_req_o,
                 bus_if.busy_o, bus_if.done_o, bus_if.timeout_o, bus_if.req_cnt_o);
      end
    end
    @(posedge clk);
    #1;
    bus_if.sw_req_i = 1'b0;
    rst_n   = 1'b1;
    exp_cnt = 0;
    idle(10, "post_reset");
  endtask

  task automatic test_normal();
    env_mode  = K_NORMAL;
    env_delay = 128;
    idle(env_delay + 8, "normal_pre");
    run_sequence(K_NORMAL, 1, 0, "normal");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      env_delay = int'($urandom_range(0, 60));
      idle(env_delay + 8, "random_pre");
      run_sequence(K_NORMAL, int'($urandom_range(1, 3)), int'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_back_to_back();
    env_delay = int'($urandom_range(0, 30));
    idle(env_delay + 8, "b2b_pre");
    run_sequence(K_NORMAL, 5, 1, "b2b_mid");
    idle(env_delay + 8, "b2b_gap");
    run_sequence(K_NORMAL, 5, 2, "b2b_done");
  endtask

  task automatic test_stuck_high();
    env_delay = 10;
    idle(env_delay + 8, "stuck_hi_pre");
    env_mode = K_STUCK_HI;
    run_sequence(K_STUCK_HI, 1, 1, "stuck_hi");
    env_mode = K_NORMAL;
    idle(env_delay + 8, "stuck_hi_post");
  endtask

  task automatic test_stuck_low();
    env_delay = int'($urandom_range(0, 30));
    idle(env_delay + 8, "stuck_lo_pre");
    env_mode = K_STUCK_LO;
    run_sequence(K_STUCK_LO, 1, 0, "stuck_lo");
    env_mode = K_NORMAL;
    idle(env_delay + 8, "stuck_lo_post");
  endtask

  // Delays that put the exit on exactly the last counted cycle (exit wins) and one past it (timeout).
  task automatic test_timeout_boundary();
    env_delay = T - 1 - S;
    idle(env_delay + 8, "bound_pre");
    run_sequence(K_NORMAL, 1, 0, "bound_exit");
    env_delay = T - S;
    idle(env_delay + 8, "bound_pre2");
    run_sequence(K_NORMAL, 1, 0, "bound_timeout");
  endtask

  task automatic test_reset_mid();
    env_delay = 20;
    idle(env_delay + 8, "rst_mid_pre");
    @(posedge clk);
    #1;
    bus_if.sw_req_i = 1'b1;
    @(posedge clk);
    #1;
    bus_if.sw_req_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus_if.arst_req_o, bus_if.busy_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_mid in ASSERT req/busy got %b%b required 11", bus_if.arst_req_o, bus_if.busy_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    n_checks++;
    if ({bus_if.arst_req_o, bus_if.busy_o, bus_if.done_o, bus_if.timeout_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid after reset req/busy/done/to got %b%b%b%b required 0000", bus_if.arst_req_o,
               bus_if.busy_o, bus_if.done_o, bus_if.timeout_o);
    end
    idle(T + 100, "rst_mid_after");
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      env_delay = int'($urandom_range(0, 8));
      idle(env_delay + 8, "sat_gap");
      run_sequence(K_NORMAL, 1, 0, "sat");
    end
    n_checks++;
`ifdef RST_REQ_CNT_EN
    if (bus_if.req_cnt_o !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation req_cnt_o got %0d required 255", bus_if.req_cnt_o);
    end
`else
    if (bus_if.req_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL saturation req_cnt_o got %0d required 0", bus_if.req_cnt_o);
    end
`endif
  endtask

  initial begin
    bus_if.sw_req_i = 1'b0;
    test_reset();
    test_normal();
    test_random();
    test_back_to_back();
    test_stuck_high();
    test_stuck_low();
    test_timeout_boundary();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
